// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and helpers for the LED pattern controller.
//   led_mode_t        - per-channel drive mode (OFF, ON, BLINK, PWM)
//   blink_half_period - clamps a blink half-period so that 0 behaves as 1
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_t;

  // Effective blink half-period in ticks: max(period, 1).
  function automatic logic [31:0] blink_half_period(input logic [31:0] period);
    return (period == 32'd0) ? 32'd1 : period;
  endfunction

endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel with its own mode/duty/period registers and
// blink state.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   tick      - prescaler timebase pulse (combinational, same cycle as wrap)
//   load      - apply strobe: load mode/duty/period, restart blink state
//   mode      - new mode to load
//   duty      - new PWM duty to load
//   period    - new blink half-period (ticks) to load
//   pwm_cnt   - shared free-running PWM counter
//   led       - registered LED drive, 1 = lit
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int PERIOD_BITS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   load,
  input  led_mode_t              mode,
  input  logic [PWM_BITS-1:0]    duty,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [PWM_BITS-1:0]    pwm_cnt,
  output logic                   led
);

  led_mode_t              mode_q, mode_n;
  logic [PWM_BITS-1:0]    duty_q, duty_n;
  logic [PERIOD_BITS-1:0] period_q, period_n;
  logic [PERIOD_BITS-1:0] cnt_q, cnt_n;
  logic                   phase_q, phase_n;
  logic [PERIOD_BITS-1:0] last_cnt;
  logic                   led_n;

  // Counter value at which the blink phase toggles.
  assign last_cnt = PERIOD_BITS'(blink_half_period(32'(period_q)) - 32'd1);

  always_comb begin
    mode_n   = mode_q;
    duty_n   = duty_q;
    period_n = period_q;
    cnt_n    = cnt_q;
    phase_n  = phase_q;
    if (load) begin
      // A load wins over a coincident tick: the counter restarts and does
      // not advance in the load cycle.
      mode_n   = mode;
      duty_n   = duty;
      period_n = period;
      cnt_n    = '0;
      phase_n  = 1'b1;
    end else if (mode_q == LED_BLINK) begin
      if (tick) begin
        if (cnt_q == last_cnt) begin
          cnt_n   = '0;
          phase_n = ~phase_q;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
    end else begin
      cnt_n = '0;
    end
  end

  // The LED register is fed from the next-state values so a newly loaded
  // mode or a blink toggle shows on led exactly one cycle later.
  always_comb begin
    led_n = 1'b0;
    case (mode_n)
      LED_ON:    led_n = 1'b1;
      LED_BLINK: led_n = phase_n;
      LED_PWM:   led_n = (pwm_cnt < duty_n);
      default:   led_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= LED_OFF;
      duty_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      led      <= 1'b0;
    end else begin
      mode_q   <= mode_n;
      duty_q   <= duty_n;
      period_q <= period_n;
      cnt_q    <= cnt_n;
      phase_q  <= phase_n;
      led      <= led_n;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: multi-channel LED driver (OFF / ON / BLINK / PWM).
// Ports:
//   io_mainClk     - single rising-edge clock
//   io_asyncReset  - asynchronous active-high reset
//   cfg_valid      - configuration write request
//   cfg_ready      - block can accept a write
//   cfg_channel    - target channel (values >= CHANNELS are accepted no-ops)
//   cfg_mode       - 0 OFF, 1 ON, 2 BLINK, 3 PWM
//   cfg_duty       - PWM duty (PWM mode only)
//   cfg_period     - blink half-period in ticks (BLINK mode only)
//   led_out        - registered LED drives, 1 = lit
//   tick_out       - registered one-cycle pulse per prescaler wrap
//
// Handshake: a write is accepted in any cycle where cfg_valid and cfg_ready
// are both high. The fields go into a single pending register and cfg_ready
// is low from the next cycle until the pending write has been applied; the
// write applies on the first prescaler tick strictly after the accept cycle,
// so channel state only ever changes on a tick boundary.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int PRESCALE    = 50000,
  parameter int PWM_BITS    = 8,
  parameter int PERIOD_BITS = 10
) (
  input  logic                                               io_mainClk,
  input  logic                                               io_asyncReset,
  input  logic                                               cfg_valid,
  output logic                                               cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_channel,
  input  logic [1:0]                                         cfg_mode,
  input  logic [PWM_BITS-1:0]                                cfg_duty,
  input  logic [PERIOD_BITS-1:0]                             cfg_period,
  output logic [CHANNELS-1:0]                                led_out,
  output logic                                               tick_out
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PS_W = $clog2(PRESCALE);

  logic [PS_W-1:0]        ps_cnt;
  logic                   tick;
  logic [PWM_BITS-1:0]    pwm_cnt;

  logic                   pend_valid;
  logic [CH_W-1:0]        pend_ch;
  led_mode_t              pend_mode;
  logic [PWM_BITS-1:0]    pend_duty;
  logic [PERIOD_BITS-1:0] pend_period;

  logic                   accept;
  logic                   apply;

  assign tick      = (ps_cnt == PS_W'(PRESCALE - 1));
  assign cfg_ready = ~pend_valid;
  assign accept    = cfg_valid & cfg_ready;
  // pend_valid only rises after the accept cycle, so a tick in the accept
  // cycle itself never applies the write.
  assign apply     = pend_valid & tick;

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      ps_cnt   <= '0;
      tick_out <= 1'b0;
      pwm_cnt  <= '0;
    end else begin
      ps_cnt   <= tick ? '0 : ps_cnt + 1'b1;
      tick_out <= tick;
      pwm_cnt  <= pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      pend_valid  <= 1'b0;
      pend_ch     <= '0;
      pend_mode   <= LED_OFF;
      pend_duty   <= '0;
      pend_period <= '0;
    end else if (accept) begin
      pend_valid  <= 1'b1;
      pend_ch     <= cfg_channel;
      pend_mode   <= led_mode_t'(cfg_mode);
      pend_duty   <= cfg_duty;
      pend_period <= cfg_period;
    end else if (apply) begin
      pend_valid  <= 1'b0;
    end
  end

  // An out-of-range pend_ch matches no channel, so the write completes the
  // handshake normally but changes nothing.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_channel #(
      .PWM_BITS   (PWM_BITS),
      .PERIOD_BITS(PERIOD_BITS)
    ) u_ch (
      .clk    (io_mainClk),
      .rst    (io_asyncReset),
      .tick   (tick),
      .load   (apply && (pend_ch == CH_W'(i))),
      .mode   (pend_mode),
      .duty   (pend_duty),
      .period (pend_period),
      .pwm_cnt(pwm_cnt),
      .led    (led_out[i])
    );
  end

endmodule
